// File: rtl/matrix_ram_reader.sv
// Purpose : streams a ROWS x COLS matrix out of a 1-cycle-latency RAM, row-major, tagged row/col/last.
// Latency : START in cycle 0 -> first RAM address cycle 1 -> first OUT_VALID cycle 3; 1 element/cycle when OUT_READY=1.
// Backpressure: a read is issued only if the 2-entry output FIFO can absorb it; OUT_* hold until accepted.
//
// Ports:
//   CLK, RST         clock (rising edge), asynchronous active-low reset
//   START            1-cycle request to read the whole matrix, ignored while BUSY or during DONE
//   BUSY, DONE       BUSY from cycle after START until DONE; DONE pulses after LAST is accepted
//   ADDRESS_A        RAM read address (always inside the matrix window)
//   Write_EN_A       RAM write enable, tied low
//   RAM_OUT          RAM read data, valid the cycle after ADDRESS_A
//   OUT_DATA/ROW/COL/LAST/VALID, OUT_READY   valid/ready element stream (registered FIFO head)
module matrix_ram_reader #(
    parameter int DATA_W    = 3,
    parameter int ADDR_W    = 4,
    parameter int ROWS      = 3,
    parameter int COLS      = 3,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] ADDRESS_A,
    output logic              Write_EN_A,
    input  logic [DATA_W-1:0] RAM_OUT,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OUT_ROW,
    output logic [1:0]        OUT_COL,
    output logic              OUT_LAST,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    localparam logic [1:0]        LAST_ROW = 2'(ROWS - 1);
    localparam logic [1:0]        LAST_COL = 2'(COLS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        row_idx;
    logic [1:0]        col_idx;

    // Read in flight: the RAM word for it appears on RAM_OUT this cycle.
    logic              rd_vld;
    logic [1:0]        rd_row;
    logic [1:0]        rd_col;
    logic              rd_last;

    // Two-entry FIFO: entry 0 is the OUT_* register set, entry 1 is the spill slot.
    logic [1:0]        fifo_cnt;
    logic [DATA_W-1:0] s1_dat;
    logic [1:0]        s1_row;
    logic [1:0]        s1_col;
    logic              s1_last;

    logic              pop;
    logic              issue;
    logic              at_last;
    logic [1:0]        cnt_nx;

    assign Write_EN_A = 1'b0;

    always_comb begin
        pop     = OUT_VALID && OUT_READY;
        // Count the in-flight word as occupied so a stalled sink never overflows the FIFO.
        issue   = (state == S_READ) &&
                  (({1'b0, fifo_cnt} + {2'b00, rd_vld} - {2'b00, pop}) < 3'd2);
        at_last = (row_idx == LAST_ROW) && (col_idx == LAST_COL);
        cnt_nx  = fifo_cnt + {1'b0, rd_vld} - {1'b0, pop};
    end

    // Sequencer: address/index walk and BUSY/DONE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            ADDRESS_A <= BASE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            rd_vld    <= 1'b0;
            rd_row    <= 2'd0;
            rd_col    <= 2'd0;
            rd_last   <= 1'b0;
        end else begin
            DONE   <= 1'b0;
            rd_vld <= issue;
            if (issue) begin
                rd_row  <= row_idx;
                rd_col  <= col_idx;
                rd_last <= at_last;
            end
            case (state)
                S_IDLE: begin
                    // DONE is still high in the cycle after completion; a START there is dropped.
                    if (START && !DONE) begin
                        state     <= S_READ;
                        BUSY      <= 1'b1;
                        ADDRESS_A <= BASE;
                        row_idx   <= 2'd0;
                        col_idx   <= 2'd0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        if (at_last) begin
                            // Park the address at the window base rather than step past the end.
                            state     <= S_DRAIN;
                            ADDRESS_A <= BASE;
                            row_idx   <= 2'd0;
                            col_idx   <= 2'd0;
                        end else begin
                            // Row-major layout is contiguous, so the address just increments.
                            ADDRESS_A <= ADDRESS_A + ADDR_W'(1);
                            if (col_idx == LAST_COL) begin
                                col_idx <= 2'd0;
                                row_idx <= row_idx + 2'd1;
                            end else begin
                                col_idx <= col_idx + 2'd1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && OUT_LAST) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output FIFO: push the returning RAM word, pop on handshake, both in one cycle allowed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fifo_cnt  <= 2'd0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_ROW   <= 2'd0;
            OUT_COL   <= 2'd0;
            OUT_LAST  <= 1'b0;
            s1_dat    <= '0;
            s1_row    <= 2'd0;
            s1_col    <= 2'd0;
            s1_last   <= 1'b0;
        end else begin
            fifo_cnt  <= cnt_nx;
            OUT_VALID <= (cnt_nx != 2'd0);
            case ({rd_vld, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        OUT_DATA <= RAM_OUT;
                        OUT_ROW  <= rd_row;
                        OUT_COL  <= rd_col;
                        OUT_LAST <= rd_last;
                    end else begin
                        s1_dat  <= RAM_OUT;
                        s1_row  <= rd_row;
                        s1_col  <= rd_col;
                        s1_last <= rd_last;
                    end
                end
                2'b01: begin
                    if (fifo_cnt == 2'd2) begin
                        OUT_DATA <= s1_dat;
                        OUT_ROW  <= s1_row;
                        OUT_COL  <= s1_col;
                        OUT_LAST <= s1_last;
                    end else begin
                        // Going empty: clear the head so a stale LAST is never visible.
                        OUT_DATA <= '0;
                        OUT_ROW  <= 2'd0;
                        OUT_COL  <= 2'd0;
                        OUT_LAST <= 1'b0;
                    end
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        OUT_DATA <= RAM_OUT;
                        OUT_ROW  <= rd_row;
                        OUT_COL  <= rd_col;
                        OUT_LAST <= rd_last;
                    end else begin
                        OUT_DATA <= s1_dat;
                        OUT_ROW  <= s1_row;
                        OUT_COL  <= s1_col;
                        OUT_LAST <= s1_last;
                        s1_dat   <= RAM_OUT;
                        s1_row   <= rd_row;
                        s1_col   <= rd_col;
                        s1_last  <= rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
